// File: rtl/jam_pkg.sv
// jam_pkg: shared state type, index sizing and cycle helper for the jam_search solver
package jam_pkg;

    localparam int MAX_N = 8;
    localparam int IDX_W = 3;

    typedef enum logic [2:0] {IDLE, FETCH, EVAL, NEXT, DONE} state_t;

    // Cycle (counted from the Start-sampling edge) in which Valid rises without pruning
    function automatic int done_cycle(input int n);
        int f;
        f = 1;
        for (int i = 2; i <= n; i++) f *= i;
        return f * (n + 2);
    endfunction

endpackage

// File: rtl/jam_search_if.sv
// jam_search_if: start/result handshake and cost-lookup bus of the assignment solver
interface jam_search_if
    import jam_pkg::*;
#(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = COST_W + 3,
    parameter int MC_W   = 16
);
    logic                 Start;
    logic [IDX_W-1:0]     W;
    logic [IDX_W-1:0]     J;
    logic [COST_W-1:0]    Cost;
    logic                 Busy;
    logic                 Valid;
    logic [SUM_W-1:0]     MinCost;
    logic [MC_W-1:0]      MatchCount;
    logic [IDX_W*N-1:0]   BestPerm;

    modport master (
        output Start, Cost,
        input  W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );

    modport slave (
        input  Start, Cost,
        output W, J, Busy, Valid, MinCost, MatchCount, BestPerm
    );
endinterface

// File: rtl/jam_next_perm.sv
// jam_next_perm: lexicographic successor of a packed permutation (identity hold on the last one)
module jam_next_perm
    import jam_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [IDX_W*N-1:0] perm,
    input  logic               last,
    output logic [IDX_W*N-1:0] succ
);
    logic [IDX_W-1:0] p [MAX_N];
    logic [IDX_W-1:0] q [MAX_N];
    logic [IDX_W-1:0] piv;
    logic [IDX_W-1:0] sw;

    // pivot at the rightmost ascent, swap with the rightmost larger element, reverse the suffix
    always_comb begin
        p = '{default: '0};
        for (int k = 0; k < N; k++) p[k] = perm[IDX_W*k +: IDX_W];
        piv = '0;
        for (int k = 0; k < N - 1; k++) if (p[k] < p[k + 1]) piv = IDX_W'(k);
        sw = '0;
        for (int k = 0; k < N; k++) if (IDX_W'(k) > piv && p[k] > p[piv]) sw = IDX_W'(k);
        q = p;
        q[piv] = p[sw];
        q[sw] = p[piv];
        succ = perm;
        if (!last)
            for (int k = 0; k < N; k++)
                succ[IDX_W*k +: IDX_W] = (IDX_W'(k) > piv) ? q[IDX_W'(N - k) + piv] : q[k];
    end
endmodule

// File: rtl/jam_search.sv
// jam_search: exhaustive N x N job-assignment search over an external synchronous cost lookup
module jam_search
    import jam_pkg::*;
#(
    parameter int N      = 8,
    parameter int COST_W = 7,
    parameter int SUM_W  = COST_W + 3,
    parameter int MC_W   = 16,
    parameter bit PRUNE  = 1'b0
) (
    input logic         CLK,
    input logic         RST,
    jam_search_if.slave bus
);
    state_t             state;
    logic [IDX_W*N-1:0] perm;
    logic [IDX_W*N-1:0] succ;
    logic [IDX_W*N-1:0] ident;
    logic [IDX_W-1:0]   pa [MAX_N];
    logic [IDX_W-1:0]   row;
    logic [SUM_W-1:0]   acc;
    logic [SUM_W-1:0]   total;
    logic [SUM_W-1:0]   part;
    logic               have_min;
    logic               last;
    logic               prune;

    jam_next_perm #(.N(N)) u_next (.perm(perm), .last(last), .succ(succ));

    // unpack perm, spot the descending final permutation, form running sums and the prune test
    always_comb begin
        ident = '0;
        for (int k = 0; k < N; k++) ident[IDX_W*k +: IDX_W] = IDX_W'(k);
        pa = '{default: '0};
        for (int k = 0; k < N; k++) pa[k] = perm[IDX_W*k +: IDX_W];
        last = 1'b1;
        for (int k = 0; k < N - 1; k++) if (pa[k] < pa[k + 1]) last = 1'b0;
        total = acc + SUM_W'(bus.Cost);
        part = (row != '0) ? total : acc;
        prune = PRUNE && row != '0 && have_min && total > bus.MinCost;
    end

    // controller: fetch one cost per row, evaluate the total, step to the next permutation
    always_ff @(posedge CLK) begin
        if (RST) begin
            state          <= IDLE;
            perm           <= '0;
            row            <= '0;
            acc            <= '0;
            have_min       <= 1'b0;
            bus.W          <= '0;
            bus.J          <= '0;
            bus.Busy       <= 1'b0;
            bus.Valid      <= 1'b0;
            bus.MinCost    <= '0;
            bus.MatchCount <= '0;
            bus.BestPerm   <= '0;
        end else begin
            bus.Valid <= 1'b0;
            case (state)
                IDLE: if (bus.Start) begin
                    state          <= FETCH;
                    bus.Busy       <= 1'b1;
                    perm           <= ident;
                    row            <= '0;
                    acc            <= '0;
                    have_min       <= 1'b0;
                    bus.MatchCount <= '0;
                    bus.W          <= '0;
                    bus.J          <= '0;
                end
                FETCH: begin
                    acc <= part;
                    if (prune) begin
                        state     <= last ? DONE : NEXT;
                        bus.Valid <= last;
                        bus.W     <= '0;
                        bus.J     <= '0;
                    end else if (row == IDX_W'(N - 1)) begin
                        state <= EVAL;
                        bus.W <= '0;
                        bus.J <= '0;
                    end else begin
                        row   <= row + 1'b1;
                        bus.W <= row + 1'b1;
                        bus.J <= pa[row + 1'b1];
                    end
                end
                EVAL: begin
                    if (!have_min || total < bus.MinCost) begin
                        bus.MinCost    <= total;
                        bus.MatchCount <= MC_W'(1);
                        bus.BestPerm   <= perm;
                        have_min       <= 1'b1;
                    end else if (total == bus.MinCost) begin
                        bus.MatchCount <= bus.MatchCount + 1'b1;
                    end
                    state     <= last ? DONE : NEXT;
                    bus.Valid <= last;
                end
                NEXT: begin
                    perm  <= succ;
                    row   <= '0;
                    acc   <= '0;
                    state <= FETCH;
                    bus.J <= succ[IDX_W-1:0];
                end
                DONE: begin
                    state    <= IDLE;
                    bus.Busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_jam_search.sv
// tb_jam_search: directed self-checking bench for jam_search (N=3, 4 and 5, with and without pruning)
module tb_jam_search;
    import jam_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] m [8][8];
    int         errors = 0;
    int         checks = 0;
    int         ca, cb, gmin, gcnt, nv, v1, v2;
    logic       bz31, bz32;
    logic [23:0] gbp;

    always #5 clk = ~clk;

    jam_search_if #(.N(3)) b3 ();
    jam_search_if #(.N(4)) b4 ();
    jam_search_if #(.N(5)) b5a ();
    jam_search_if #(.N(5)) b5b ();

    jam_search #(.N(3)) d3 (.CLK(clk), .RST(rst), .bus(b3));
    jam_search #(.N(4)) d4 (.CLK(clk), .RST(rst), .bus(b4));
    jam_search #(.N(5), .PRUNE(1'b0)) d5a (.CLK(clk), .RST(rst), .bus(b5a));
    jam_search #(.N(5), .PRUNE(1'b1)) d5b (.CLK(clk), .RST(rst), .bus(b5b));

    // cost lookups with one cycle of latency from W/J
    always_ff @(posedge clk) begin
        b3.Cost  <= m[b3.W][b3.J];
        b4.Cost  <= m[b4.W][b4.J];
        b5a.Cost <= m[b5a.W][b5a.J];
        b5b.Cost <= m[b5b.W][b5b.J];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // brute force over every worker->job tuple in lexicographic order, keeping only permutations
    task automatic golden(input int n, output int mn, output int mc, output logic [23:0] bp);
        int d [8];
        int lim, t, tot;
        bit ok;
        lim = 1;
        for (int i = 0; i < n; i++) lim *= n;
        mn = -1;
        mc = 0;
        bp = '0;
        for (int idx = 0; idx < lim; idx++) begin
            t = idx;
            for (int r = n - 1; r >= 0; r--) begin
                d[r] = t % n;
                t = t / n;
            end
            ok = 1'b1;
            for (int a = 0; a < n; a++)
                for (int b = a + 1; b < n; b++)
                    if (d[a] == d[b]) ok = 1'b0;
            if (ok) begin
                tot = 0;
                for (int r = 0; r < n; r++) tot += int'(m[r][d[r]]);
                if (mn < 0 || tot < mn) begin
                    mn = tot;
                    mc = 1;
                    bp = '0;
                    for (int r = 0; r < n; r++) bp[3*r +: 3] = d[r][2:0];
                end else if (tot == mn) begin
                    mc++;
                end
            end
        end
    endtask

    task automatic rand_matrix(input int hi);
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = 7'($urandom_range(0, hi));
    endtask

    task automatic run3(output int vc);
        b3.Start = 1'b1;
        @(negedge clk);
        b3.Start = 1'b0;
        vc = -1;
        for (int c = 1; c <= 5000 && vc < 0; c++) begin
            if (b3.Valid) vc = c;
            @(negedge clk);
        end
    endtask

    task automatic run4(output int vc);
        b4.Start = 1'b1;
        @(negedge clk);
        b4.Start = 1'b0;
        vc = -1;
        for (int c = 1; c <= 5000 && vc < 0; c++) begin
            if (b4.Valid) vc = c;
            @(negedge clk);
        end
    endtask

    task automatic run5(output int va, output int vb);
        b5a.Start = 1'b1;
        b5b.Start = 1'b1;
        @(negedge clk);
        b5a.Start = 1'b0;
        b5b.Start = 1'b0;
        va = -1;
        vb = -1;
        for (int c = 1; c <= 5000 && (va < 0 || vb < 0); c++) begin
            if (b5a.Valid && va < 0) va = c;
            if (b5b.Valid && vb < 0) vb = c;
            @(negedge clk);
        end
    endtask

    initial begin
        b3.Start = 1'b0;
        b4.Start = 1'b0;
        b5a.Start = 1'b0;
        b5b.Start = 1'b0;
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = 7'd0;
        repeat (3) @(negedge clk);
        chk("reset_busy", b3.Busy, 0);
        chk("reset_valid", b3.Valid, 0);
        chk("reset_mincost", b3.MinCost, 0);
        chk("reset_matchcount", b3.MatchCount, 0);
        chk("reset_bestperm", b3.BestPerm, 0);
        chk("reset_wj", {b3.W, b3.J}, 0);
        rst = 1'b0;
        @(negedge clk);

        // N=3 diagonal zero matrix
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = (w == j) ? 7'd0 : 7'd10;
        run3(ca);
        chk("n3_diag_cycle", ca, 30);
        chk("n3_diag_mincost", b3.MinCost, 0);
        chk("n3_diag_count", b3.MatchCount, 1);
        chk("n3_diag_best", b3.BestPerm, 'h088);
        chk("n3_idle_busy", b3.Busy, 0);
        repeat (4) @(negedge clk);
        chk("n3_hold_mincost", b3.MinCost, 0);

        // N=3 extra Start pulses in FETCH, EVAL and DONE are ignored; one after DONE is taken
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = (j == (w + 1) % 3) ? 7'd2 : 7'd9;
        b3.Start = 1'b1;
        @(negedge clk);
        b3.Start = 1'b0;
        nv = 0;
        v1 = -1;
        v2 = -1;
        bz31 = 1'bx;
        bz32 = 1'bx;
        for (int c = 1; c <= 70; c++) begin
            if (b3.Valid) begin
                nv++;
                if (v1 < 0) v1 = c;
                else v2 = c;
            end
            if (c == 31) bz31 = b3.Busy;
            if (c == 32) bz32 = b3.Busy;
            b3.Start = (c == 5 || c == 29 || c == 30 || c == 31);
            @(negedge clk);
        end
        b3.Start = 1'b0;
        chk("n3_start_first_valid", v1, 30);
        chk("n3_start_second_valid", v2, 61);
        chk("n3_start_valid_count", nv, 2);
        chk("n3_busy_after_done", bz31, 0);
        chk("n3_busy_restart", bz32, 1);
        chk("n3_shift_mincost", b3.MinCost, 6);
        chk("n3_shift_count", b3.MatchCount, 1);
        chk("n3_shift_best", b3.BestPerm, 'h011);

        // N=4 anti-diagonal minimum
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = (w + j == 3) ? 7'd1 : 7'd50;
        run4(ca);
        chk("n4_anti_cycle", ca, 144);
        chk("n4_anti_mincost", b4.MinCost, 4);
        chk("n4_anti_count", b4.MatchCount, 1);
        chk("n4_anti_best", b4.BestPerm, 'h053);

        // N=4 reset in the middle of a search, then a fresh search on a new matrix
        rand_matrix(15);
        b4.Start = 1'b1;
        @(negedge clk);
        b4.Start = 1'b0;
        for (int c = 1; c < 50; c++) @(negedge clk);
        chk("n4_busy_before_rst", b4.Busy, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("n4_rst_busy", b4.Busy, 0);
        chk("n4_rst_valid", b4.Valid, 0);
        chk("n4_rst_mincost", b4.MinCost, 0);
        chk("n4_rst_count", b4.MatchCount, 0);
        chk("n4_rst_best", b4.BestPerm, 0);
        chk("n4_rst_wj", {b4.W, b4.J}, 0);
        rst = 1'b0;
        rand_matrix(15);
        golden(4, gmin, gcnt, gbp);
        run4(ca);
        chk("n4_post_rst_cycle", ca, 144);
        chk("n4_post_rst_mincost", b4.MinCost, gmin);
        chk("n4_post_rst_count", b4.MatchCount, gcnt);
        chk("n4_post_rst_best", b4.BestPerm, gbp);

        // N=5 every total ties: pruning must never drop a tie
        for (int w = 0; w < 8; w++)
            for (int j = 0; j < 8; j++)
                m[w][j] = 7'(j);
        run5(ca, cb);
        chk("n5_tie_cycle_p0", ca, 840);
        chk("n5_tie_cycle_p1", cb, 840);
        chk("n5_tie_mincost_p0", b5a.MinCost, 10);
        chk("n5_tie_count_p0", b5a.MatchCount, 120);
        chk("n5_tie_best_p0", b5a.BestPerm, 'h4688);
        chk("n5_tie_mincost_p1", b5b.MinCost, 10);
        chk("n5_tie_count_p1", b5b.MatchCount, 120);
        chk("n5_tie_best_p1", b5b.BestPerm, 'h4688);

        // N=5 random matrices, wide range (pruning active) and narrow range (many ties)
        for (int t = 0; t < 2; t++) begin
            rand_matrix(t == 0 ? 127 : 3);
            golden(5, gmin, gcnt, gbp);
            run5(ca, cb);
            chk("n5_rand_cycle_p0", ca, 840);
            chk("n5_rand_cycle_p1_bound", (cb > 0 && cb <= 840), 1);
            chk("n5_rand_mincost_p0", b5a.MinCost, gmin);
            chk("n5_rand_count_p0", b5a.MatchCount, gcnt);
            chk("n5_rand_best_p0", b5a.BestPerm, gbp);
            chk("n5_rand_mincost_p1", b5b.MinCost, gmin);
            chk("n5_rand_count_p1", b5b.MatchCount, gcnt);
            chk("n5_rand_best_p1", b5b.BestPerm, gbp);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/jam_search.md
# jam_search

Parametrised exhaustive job-assignment solver: for an N×N cost matrix held in an external synchronous lookup, it walks all N! worker→job permutations in lexicographic order and reports the minimum total cost, the number of permutations reaching it, and the first permutation that does. It is the generalised successor of the fixed 8×8 assignment engine. Over that engine it adds run-time Start/Busy control, a best-permutation output and optional partial-sum pruning. It sits between the testbench/host cost ROM and the result-collection logic.

## Interface
- N, 8: workers = jobs, legal range 2..8
- COST_W, 7: width of one Cost entry
- SUM_W, COST_W+3: width of MinCost and accumulator; cannot overflow for N≤8
- MC_W, 16: MatchCount width; holds 8! = 40320
- PRUNE, 0: 1 enables early abort of permutations whose partial sum already exceeds MinCost
- CLK  in  1  single clock, rising edge
- RST  in  1  synchronous, active-high reset
- Start  in  1  one-cycle request to begin a search; ignored while Busy
- W  out  3  row (worker) address of the cost lookup
- J  out  3  column (job) address of the cost lookup
- Cost  in  COST_W  Cost[W][J]; the external lookup returns it exactly one cycle after W/J are driven
- Busy  out  1  high from the cycle after Start is accepted through the DONE cycle
- Valid  out  1  one-cycle pulse when the results are final
- MinCost  out  SUM_W  minimum total cost
- MatchCount  out  MC_W  number of permutations whose total equals MinCost
- BestPerm  out  3*N  job assigned to worker r in bits [3r+2:3r], for the lexicographically first minimum

## Operation
- States: IDLE, FETCH, EVAL, NEXT, DONE. All outputs reset to 0, and the state resets to IDLE.
- IDLE: if Start is high, go to FETCH. On entry, perm is set to identity, row to 0, acc to 0, have_min to 0, and MatchCount to 0. Result outputs hold their previous values until the first EVAL.
- FETCH: drive W=row and J=perm[row].
  - If row≥1, acc += Cost, which is the return for row−1.
  - row increments each cycle.
  - After the row N−1 cycle, go to EVAL.
- EVAL: total = acc + Cost.
  - If have_min is 0 or total < MinCost: MinCost=total, MatchCount=1, BestPerm=perm, have_min=1.
  - Else if total == MinCost: MatchCount += 1.
  - If perm is descending (the last permutation), go to DONE; otherwise go to NEXT.
- NEXT: replace perm with its lexicographic successor in one cycle. This is the standard pivot / swap-with-smallest-greater / reverse-suffix algorithm. Clear row and acc, then go to FETCH.
- DONE: Valid=1 for this cycle only, then go to IDLE.
- W and J are 0 outside FETCH.
- Pruning (PRUNE=1): in FETCH with row≥1 and have_min=1, if acc+Cost > MinCost, abort the permutation. Go to NEXT, or to DONE if perm is the last permutation. This is a strict comparison, so tied permutations are never pruned and MatchCount stays exact.
- Outputs with PRUNE=1 are bit-identical to PRUNE=0; only the cycle count differs.
- RST in any state returns to IDLE, clears all outputs and ignores in-flight Cost.

## Timing
- Cost per permutation without pruning: N FETCH + 1 EVAL + 1 NEXT = N+2 cycles. The last permutation omits NEXT.
- Edge 0 samples Start. Valid is high in cycle N!·(N+2) after edge 0, e.g. cycle 30 for N=3 and 403200 for N=8.
- With PRUNE=1, Valid arrives no later than the PRUNE=0 count.
- Start concurrent with RST: RST wins.
- Start high during Busy: ignored, and no restart occurs.
- Start in the DONE cycle: ignored. It is accepted from the following IDLE cycle.
- MinCost, MatchCount and BestPerm are stable from Valid until the next accepted Start.

## Structure
- Shared package jam_pkg holds the state enum, MAX_N=8, the IDX_W=3 index width, and the function for the N! cycle constant used by the bench.
- Sub-module jam_next_perm: combinational with a parameter N. Inputs are perm and a last flag; the output is the successor permutation. The top instantiates it once and registers its output in NEXT.
- The top module holds the FSM, the row counter, the accumulator, the compare/update logic and the prune comparator.

## Test plan
- N=3, Cost[w][j] = (w==j)?0:10, PRUNE=0 → MinCost=0, MatchCount=1, BestPerm={2,1,0} (identity), Valid in cycle 30.
- N=8, Cost[w][j]=j → every total is 28, so MinCost=28, MatchCount=40320, BestPerm=identity, Valid in cycle 403200.
- N=4, Cost[w][j] = (w+j==3)?1:50 → MinCost=4, MatchCount=1, BestPerm worker0→3, 1→2, 2→1, 3→0.
- N=5 with a random matrix, run with PRUNE=0 and PRUNE=1 → identical MinCost, MatchCount and BestPerm; the PRUNE=1 Valid arrives at or before cycle 840.
- N=4: Start, then RST asserted at cycle 50, then a new Start with a different matrix → all outputs are 0 after RST, and the second result matches the golden model with no carry-over.
- N=3: Start pulsed again at cycles 5 and 29, and in the DONE cycle → all ignored; one Valid occurs in cycle 30, and a Start one cycle after DONE is accepted.
